// File: rtl/adc_capture_mc_if.sv
// Stream bundle for adc_capture_mc: the ADC capture input and the PS readout output.
// The DUT uses the slave modport and the feeding/consuming logic uses the master modport.
interface adc_capture_mc_if #(
  parameter int NUM_CH = 2,
  parameter int WORD_W = 128,
  parameter int OUT_W  = 32
);
  logic [NUM_CH*WORD_W-1:0] s_axis_tdata;
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic [OUT_W-1:0]         m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tready;
  logic                     m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/adc_capture_mc.sv
// Multi-channel ADC burst capture into per-channel RAMs with sequential AXI-Stream readout.
// Optional per-channel header beat enabled by defining ADC_CAPTURE_HEADER_EN.
//   state   | meaning
//   IDLE    | waiting for arm
//   ARMED   | length/enables latched, waiting for trigger
//   CAPTURE | storing valid words until the latched length is reached
//   READOUT | streaming enabled channels out, tlast on the final beat
module adc_capture_mc #(
  parameter int NUM_CH = 2,
  parameter int WORD_W = 128,
  parameter int OUT_W  = 32,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trigger,
  input  logic [CNT_W-1:0]  capture_len,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              readout_en,
  input  logic              flush,
  adc_capture_mc_if.slave   axis,
  output logic [1:0]        state_o,
  output logic              trig_missed
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BEATS  = WORD_W / OUT_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef ADC_CAPTURE_HEADER_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [NUM_CH*WORD_W-1:0] s_data_q;
  logic                     s_valid_q;
  logic                     trig_q;
  logic [CNT_W-1:0]         len_q, len_clamped, wr_cnt;
  logic [NUM_CH-1:0]        ch_en_q;
  logic                     wr_en, wr_last;

  logic [CH_W-1:0]   g_ch, first_ch, nxt_ch;
  logic              first_found, nxt_found;
  logic [CNT_W-1:0]  g_word;
  logic [BEAT_W-1:0] g_beat;
  logic              g_hdr, g_done;
  logic              issue, iss_last, room, pop;

  logic              p1_v, p1_hdr, p1_last;
  logic [CH_W-1:0]   p1_ch;
  logic [BEAT_W-1:0] p1_beat;
  logic [OUT_W-1:0]  push_data;

  logic [OUT_W-1:0]  f_data [2];
  logic              f_last [2];
  logic              f_rp, f_wp;
  logic [1:0]        f_cnt;

  logic [NUM_CH*WORD_W-1:0] rd_flat;

  assign len_clamped = (capture_len == '0 || capture_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : capture_len;
  assign wr_en   = s_valid_q && ((state == ST_ARMED && trig_q) || state == ST_CAPTURE);
  assign wr_last = wr_en && (wr_cnt + CNT_W'(1) == len_q);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_mem
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_word;
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_cnt[AW-1:0]] <= s_data_q[c*WORD_W +: WORD_W];
      rd_word <= mem[g_word[AW-1:0]];
    end
    assign rd_flat[c*WORD_W +: WORD_W] = rd_word;
  end

  // lowest enabled channel overall, and lowest enabled channel above the current one
  always_comb begin
    first_ch    = '0;
    first_found = 1'b0;
    nxt_ch      = '0;
    nxt_found   = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (ch_en_q[c]) begin
        first_ch    = CH_W'(c);
        first_found = 1'b1;
      end
      if (ch_en_q[c] && c > int'(g_ch)) begin
        nxt_ch    = CH_W'(c);
        nxt_found = 1'b1;
      end
    end
  end

  assign axis.s_axis_tready = 1'b1;
  assign axis.m_axis_tvalid = (state == ST_READOUT) && readout_en && (f_cnt != 2'd0);
  assign axis.m_axis_tdata  = f_data[f_rp];
  assign axis.m_axis_tlast  = axis.m_axis_tvalid && f_last[f_rp];
  assign state_o            = state;

  assign pop      = axis.m_axis_tvalid && axis.m_axis_tready;
  // one read in flight plus the two skid entries must never exceed the buffer
  assign room     = (int'(f_cnt) + int'(p1_v) - int'(pop)) < 2;
  assign issue    = (state == ST_READOUT) && !g_done && room;
  assign iss_last = !g_hdr && (g_beat == BEAT_W'(BEATS - 1)) &&
                    (g_word == len_q - CNT_W'(1)) && !nxt_found;

  always_comb begin
    push_data = rd_flat[int'(p1_ch)*WORD_W + int'(p1_beat)*OUT_W +: OUT_W];
    if (HDR_EN && p1_hdr) begin
      push_data        = '0;
      push_data[7:0]   = 8'(p1_ch);
      push_data[23:8]  = 16'(len_q);
      push_data[31:24] = 8'hA5;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (arm) state_nxt = ST_ARMED;
      ST_ARMED:   if (trig_q) state_nxt = wr_last ? ST_READOUT : ST_CAPTURE;
      ST_CAPTURE: if (wr_last) state_nxt = ST_READOUT;
      ST_READOUT: if (ch_en_q == '0 || (pop && axis.m_axis_tlast)) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_data_q    <= '0;
      s_valid_q   <= 1'b0;
      trig_q      <= 1'b0;
      trig_missed <= 1'b0;
      len_q       <= '0;
      ch_en_q     <= '0;
      wr_cnt      <= '0;
      g_ch        <= '0;
      g_word      <= '0;
      g_beat      <= '0;
      g_hdr       <= 1'b0;
      g_done      <= 1'b0;
      p1_v        <= 1'b0;
      p1_ch       <= '0;
      p1_beat     <= '0;
      p1_hdr      <= 1'b0;
      p1_last     <= 1'b0;
      f_rp        <= 1'b0;
      f_wp        <= 1'b0;
      f_cnt       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_last[i] <= 1'b0;
      end
    end else begin
      s_data_q  <= axis.s_axis_tdata;
      s_valid_q <= axis.s_axis_tvalid;
      trig_q    <= trigger;

      if (flush || arm) trig_missed <= 1'b0;
      else if (trig_q && (state == ST_CAPTURE || state == ST_READOUT)) trig_missed <= 1'b1;

      if (state == ST_IDLE && arm && !flush) begin
        len_q   <= len_clamped;
        ch_en_q <= ch_enable;
      end

      if (flush || state == ST_IDLE) wr_cnt <= '0;
      else if (wr_en) wr_cnt <= wr_cnt + CNT_W'(1);

      // the beat generator idles preloaded with the first enabled channel
      if (flush || state != ST_READOUT) begin
        g_ch   <= first_ch;
        g_word <= '0;
        g_beat <= '0;
        g_hdr  <= HDR_EN;
        g_done <= !first_found;
      end else if (issue) begin
        if (g_hdr) begin
          g_hdr <= 1'b0;
        end else if (g_beat == BEAT_W'(BEATS - 1)) begin
          g_beat <= '0;
          if (g_word == len_q - CNT_W'(1)) begin
            g_word <= '0;
            if (nxt_found) begin
              g_ch  <= nxt_ch;
              g_hdr <= HDR_EN;
            end else begin
              g_done <= 1'b1;
            end
          end else begin
            g_word <= g_word + CNT_W'(1);
          end
        end else begin
          g_beat <= g_beat + BEAT_W'(1);
        end
      end

      p1_v <= issue && !flush;
      if (issue) begin
        p1_ch   <= g_ch;
        p1_beat <= g_beat;
        p1_hdr  <= g_hdr;
        p1_last <= iss_last;
      end

      if (flush) begin
        f_rp  <= 1'b0;
        f_wp  <= 1'b0;
        f_cnt <= 2'd0;
      end else begin
        if (p1_v) begin
          f_data[f_wp] <= push_data;
          f_last[f_wp] <= p1_last;
          f_wp         <= ~f_wp;
        end
        if (pop) f_rp <= ~f_rp;
        f_cnt <= f_cnt + 2'(p1_v) - 2'(pop);
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_mc.sv
// Scoreboard bench for adc_capture_mc: frames predicted from captured words, checked by a monitor.
module tb_adc_capture_mc;
  localparam int NUM_CH = 2;
  localparam int WORD_W = 128;
  localparam int OUT_W  = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;
  localparam int BEATS  = WORD_W / OUT_W;

  logic clk = 1'b0;
  logic rst, arm, trigger, readout_en, flush, trig_missed;
  logic [CNT_W-1:0]  capture_len;
  logic [NUM_CH-1:0] ch_enable;
  logic [1:0]        state_o;

  always #5 clk = ~clk;

  adc_capture_mc_if #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .OUT_W(OUT_W)) axis ();

  adc_capture_mc #(
    .NUM_CH(NUM_CH), .WORD_W(WORD_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .trigger(trigger), .capture_len(capture_len),
    .ch_enable(ch_enable), .readout_en(readout_en), .flush(flush), .axis(axis),
    .state_o(state_o), .trig_missed(trig_missed)
  );

  int total = 0;
  int bad = 0;
  int frame_beats = 0;
  bit rdy_rand = 1'b0;
  logic [OUT_W:0]    exp_q [$];
  logic [WORD_W-1:0] words [NUM_CH][DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    axis.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axis.m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: pops expectations on handshakes and checks held beats are replayed unchanged
  initial begin
    logic             pend_v;
    logic [OUT_W:0]   pend;
    logic [OUT_W:0]   e;
    pend_v = 1'b0;
    pend   = '0;
    forever begin
      @(negedge clk);
      if (state_o != 2'd3) pend_v = 1'b0;
      if (axis.m_axis_tvalid === 1'b1) begin
        if (pend_v) check("hold_stable", 64'({axis.m_axis_tlast, axis.m_axis_tdata}), 64'(pend));
        if (axis.m_axis_tready) begin
          frame_beats++;
          pend_v = 1'b0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got %0h expected none", axis.m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'({axis.m_axis_tlast, axis.m_axis_tdata}), 64'(e));
          end
        end else begin
          pend_v = 1'b1;
          pend   = {axis.m_axis_tlast, axis.m_axis_tdata};
        end
      end
    end
  end

  // vmode: 0 always valid, 1 alternating starting valid, 2 random
  task automatic start_capture(input int len_req, input logic [1:0] en, input int vmode,
                               input bit hold, input bit ramp);
    int eff, n, cyc, last_c;
    logic v;
    logic [OUT_W-1:0] h;
    eff = (len_req == 0 || len_req > DEPTH) ? DEPTH : len_req;
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < DEPTH; k++)
        words[c][k] = ramp ? {4{32'(c*16 + k)}} : {$urandom, $urandom, $urandom, $urandom};
    last_c = -1;
    for (int c = 0; c < NUM_CH; c++) if (en[c]) last_c = c;
    for (int c = 0; c < NUM_CH; c++) begin
      if (en[c]) begin
`ifdef ADC_CAPTURE_HEADER_EN
        h = '0;
        h[7:0] = 8'(c);
        h[23:8] = 16'(eff);
        h[31:24] = 8'hA5;
        exp_q.push_back({1'b0, h});
`endif
        for (int k = 0; k < eff; k++)
          for (int b = 0; b < BEATS; b++)
            exp_q.push_back({(c == last_c && k == eff - 1 && b == BEATS - 1),
                             words[c][k][b*OUT_W +: OUT_W]});
      end
    end
    frame_beats = 0;
    capture_len = CNT_W'(len_req);
    ch_enable = en;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    n = 0;
    cyc = 0;
    while (n < eff) begin
      trigger = hold || (cyc == 0);
      case (vmode)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      axis.s_axis_tvalid = v;
      if (v) begin
        for (int c = 0; c < NUM_CH; c++) axis.s_axis_tdata[c*WORD_W +: WORD_W] = words[c][n];
        n++;
      end else begin
        axis.s_axis_tdata = {8{$urandom}};
      end
      tick();
      cyc++;
    end
    trigger = 1'b0;
    axis.s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!(exp_q.size() == 0 && state_o == 2'd0) && cyc < 3000) begin
      tick();
      cyc++;
    end
    check({name, "_state"}, 64'(state_o), 64'd0);
    check({name, "_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_beats(input int nb);
    int cyc;
    cyc = 0;
    while (frame_beats < nb && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("reach_beats", 64'(frame_beats >= nb), 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    arm = 1'b0;
    trigger = 1'b0;
    flush = 1'b0;
    readout_en = 1'b1;
    capture_len = '0;
    ch_enable = '0;
    axis.s_axis_tdata = '0;
    axis.s_axis_tvalid = 1'b0;
    repeat (3) tick();
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_tvalid", 64'(axis.m_axis_tvalid), 64'd0);
    check("rst_tdata", 64'(axis.m_axis_tdata), 64'd0);
    check("rst_tlast", 64'(axis.m_axis_tlast), 64'd0);
    check("rst_missed", 64'(trig_missed), 64'd0);
    check("rst_sready", 64'(axis.s_axis_tready), 64'd1);
    rst = 1'b1;
    tick();

    start_capture(3, 2'b11, 0, 1'b0, 1'b1);
    wait_done("ramp_both");

    start_capture(0, 2'b10, 0, 1'b0, 1'b1);
    wait_done("full_ch1");

    start_capture(4, 2'b11, 1, 1'b0, 1'b1);
    wait_done("toggle_valid");

    rdy_rand = 1'b1;
    start_capture(8, 2'b11, 2, 1'b0, 1'b0);
    wait_beats(7);
    readout_en = 1'b0;
    repeat (5) begin
      tick();
      check("stall_tvalid", 64'(axis.m_axis_tvalid), 64'd0);
    end
    readout_en = 1'b1;
    wait_done("stall_frame");
    rdy_rand = 1'b0;

    start_capture(2, 2'b01, 0, 1'b1, 1'b1);
    wait_done("hold_trig");
    check("missed_set", 64'(trig_missed), 64'd1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("missed_clr", 64'(trig_missed), 64'd0);
    check("armed", 64'(state_o), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", 64'(state_o), 64'd0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (3) tick();
    check("idle_trig_ignored", 64'(state_o), 64'd0);

    start_capture(6, 2'b11, 0, 1'b0, 1'b0);
    wait_beats(4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    check("flush_tvalid", 64'(axis.m_axis_tvalid), 64'd0);
    check("flush_state", 64'(state_o), 64'd0);
    start_capture(5, 2'b11, 0, 1'b0, 1'b0);
    wait_done("after_flush");

    start_capture(3, 2'b00, 0, 1'b0, 1'b0);
    wait_done("no_channels");

    for (int i = 0; i < 4; i++) begin
      rdy_rand = 1'($urandom_range(0, 1));
      start_capture(int'($urandom_range(0, 20)), 2'($urandom_range(0, 3)), 2, 1'b0, 1'b0);
      wait_done("random");
    end
    rdy_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
